// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width: enough to count WIDTH steps, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done request bus carrying operands in and the difference out.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] da;
  logic [WIDTH-1:0] db;
  logic             dbin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ddiff;
  logic             dborrow;

  modport master (
    output start, da, db, dbin,
    input  busy, done, ddiff, dborrow
  );

  modport slave (
    input  start, da, db, dbin,
    output busy, done, ddiff, dborrow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: one LSB-first bit per clock through a single cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] d_next;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New difference bit enters at the MSB so the LSB-first stream lands in place.
  assign d_next = (d_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      d_sr        <= '0;
      br          <= 1'b0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ddiff   <= '0;
      bus.dborrow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr     <= bus.da;
            b_sr     <= bus.db;
            br       <= bus.dbin;
            d_sr     <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next;
          br   <= cell_bout;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.ddiff   <= d_next;
            bus.dborrow <= cell_bout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed timing checks at WIDTH=4, then lockstep WIDTH=1/4/8 against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] da;
  logic [7:0] db;
  logic       dbin;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(1)) bus1 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  assign bus1.start = start;
  assign bus1.da    = da[0:0];
  assign bus1.db    = db[0:0];
  assign bus1.dbin  = dbin;
  assign bus4.start = start;
  assign bus4.da    = da[3:0];
  assign bus4.db    = db[3:0];
  assign bus4.dbin  = dbin;
  assign bus8.start = start;
  assign bus8.da    = da;
  assign bus8.db    = db;
  assign bus8.dbin  = dbin;

  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  always @(negedge clk)
    if ((bus1.busy && bus1.done) || (bus4.busy && bus4.done) || (bus8.busy && bus8.done))
      overlap++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {borrow, diff} = ({0,a} - b - bin) mod 2^(w+1), operands truncated to w bits.
  function automatic logic [63:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic bin);
    longint wm = (longint'(1) << w) - 1;
    longint rm = (longint'(1) << (w + 1)) - 1;
    longint r  = (longint'(a) & wm) - (longint'(b) & wm) - longint'(bin);
    return 64'(r & rm);
  endfunction

  function automatic logic [63:0] res4();
    return 64'({bus4.dborrow, bus4.ddiff});
  endfunction

  // Single WIDTH=4 operation with per-cycle busy/done checks; returns in the done cycle.
  task automatic w4_timed(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input logic [63:0] exp, input string tag);
    da = 8'(a); db = 8'(b); dbin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check({tag, "_busy"}, 64'(bus4.busy), 64'd1);
      check({tag, "_nodone"}, 64'(bus4.done), 64'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(bus4.done), 64'd1);
    check({tag, "_idle"}, 64'(bus4.busy), 64'd0);
    check({tag, "_res"}, res4(), exp);
    check({tag, "_model"}, res4(), ref_sub(4, 8'(a), 8'(b), bin));
  endtask

  // Same operands to all three widths; each must finish at cycle WIDTH+1 with the model result.
  task automatic lockstep_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int c1 = 0, c4 = 0, c8 = 0;
    logic [63:0] r1 = '0, r4 = '0, r8 = '0;
    da = a; db = b; dbin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (bus1.done) begin c1 = c; r1 = 64'({bus1.dborrow, bus1.ddiff}); end
      if (bus4.done) begin c4 = c; r4 = res4(); end
      if (bus8.done) begin c8 = c; r8 = 64'({bus8.dborrow, bus8.ddiff}); end
      if (c < 10) @(negedge clk);
    end
    check("w1_latency", 64'(c1), 64'd2);
    check("w4_latency", 64'(c4), 64'd5);
    check("w8_latency", 64'(c8), 64'd9);
    check("w1_result", r1, ref_sub(1, a, b, bin));
    check("w4_result", r4, ref_sub(4, a, b, bin));
    check("w8_result", r8, ref_sub(8, a, b, bin));
  endtask

  initial begin
    int          ndone;
    int          got;
    int          cyc;
    int          last_done;
    logic [8:0]  q[$];
    logic [8:0]  op;

    rst = 1'b1; start = 1'b0; da = '0; db = '0; dbin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus4.busy), 64'd0);
    check("rst_done", 64'(bus4.done), 64'd0);
    check("rst_result", res4(), 64'd0);
    check("rst_result_w8", 64'({bus8.dborrow, bus8.ddiff}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    w4_timed(4'b0010, 4'b1100, 1'b0, 64'h16, "tp1");
    w4_timed(4'b1100, 4'b0010, 1'b0, 64'h0A, "tp2a");
    w4_timed(4'b0000, 4'b0000, 1'b1, 64'h1F, "tp2b");
    w4_timed(4'b1111, 4'b1111, 1'b1, 64'h1F, "tp2c");
    @(negedge clk);

    // A start pulse during SHIFT must be ignored.
    da = 8'h08; db = 8'h01; dbin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); da = 8'h05; db = 8'h03; dbin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ign_done", 64'(bus4.done), 64'd1);
    check("ign_res", res4(), 64'h07);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus4.done || bus4.busy) ndone++;
    end
    check("ign_no_second_op", 64'(ndone), 64'd0);

    // Reset in cycle 3 discards the operation and clears the held result.
    da = 8'h03; db = 8'h09; dbin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy", 64'(bus4.busy), 64'd0);
    check("midrst_done", 64'(bus4.done), 64'd0);
    check("midrst_result", res4(), 64'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    w4_timed(4'b1001, 4'b0011, 1'b1, 64'h05, "post_rst");
    @(negedge clk);

    // start held high: operands swapped in each done cycle, one result per 5 cycles.
    op = 9'($urandom_range(0, 511));
    da = 8'(op[8:5]); db = 8'(op[4:1]); dbin = op[0]; start = 1'b1;
    q.push_back(op);
    got = 0; cyc = 0; last_done = 0;
    for (int i = 0; i < 60 && got < 6; i++) begin
      @(negedge clk);
      cyc++;
      if (bus4.done) begin
        check("b2b_gap", 64'(cyc - last_done), 64'd5);
        last_done = cyc;
        op = q.pop_front();
        check("b2b_res", res4(), ref_sub(4, 8'(op[8:5]), 8'(op[4:1]), op[0]));
        got++;
        if (got < 6) begin
          op = 9'($urandom_range(0, 511));
          da = 8'(op[8:5]); db = 8'(op[4:1]); dbin = op[0];
          q.push_back(op);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(got), 64'd6);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 512; v++)
      lockstep_op(8'(v[8:5]), 8'(v[4:1]), v[0]);
    for (int i = 0; i < 1500; i++)
      lockstep_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    check("busy_done_overlap", 64'(overlap), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
